// File: rtl/bcd_cascade_pkg.sv
// Shared limits and the load-clamp helper for the cascaded modulo-RADIX counter.
package bcd_cascade_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_RADIX  = 16;

    // Out-of-range load digits collapse to zero rather than aliasing modulo 2**DW.
    function automatic int clamp_digit(input int value, input int radix);
        return (value >= radix) ? 0 : value;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One modulo-RADIX digit with synchronous load and a single-step up/down move.
module bcd_digit_cell #(
    parameter  int RADIX = 10,
    localparam int DW    = $clog2(RADIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    input  logic          step,
    input  logic          up_down,
    output logic [DW-1:0] q_digit,
    output logic          at_term
);

    localparam logic [DW-1:0] LAST = DW'(RADIX - 1);

    logic [DW-1:0] digit_q;
    logic [DW-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = ld_val;
        end else if (step) begin
            if (up_down) begin
                digit_d = (digit_q == LAST) ? '0 : digit_q + DW'(1);
            end else begin
                digit_d = (digit_q == '0) ? LAST : digit_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_digit = digit_q;
    assign at_term = up_down ? (digit_q == LAST) : (digit_q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-RADIX up/down counter with load clamping, tc and ovf/load_err pulses.
// Define BCD_CASCADE_COUNTER_SAT_EN to hold at full scale instead of wrapping.
module bcd_cascade_counter
    import bcd_cascade_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int RADIX  = 10,
    localparam int DW     = $clog2(RADIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic                 up_down,
    input  logic [DIGITS*DW-1:0] data_in,
    output logic [DIGITS*DW-1:0] q,
    output logic                 tc,
    output logic                 ovf,
    output logic                 load_err
);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS || RADIX < 2 || RADIX > MAX_RADIX) begin : g_bad_cfg
        $error("bcd_cascade_counter: DIGITS or RADIX out of range");
    end

    logic [DIGITS-1:0] at_term;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] bad_digit;
    logic [DIGITS:0]   chain;
    logic              all_term;
    logic              en_eff;
    logic              ovf_q, ovf_d;
    logic              load_err_q, load_err_d;

    assign chain[0] = 1'b1;
    assign all_term = chain[DIGITS];

`ifdef BCD_CASCADE_COUNTER_SAT_EN
    // At the limit no digit may move; ovf still reports the attempted step.
    assign en_eff = en & ~all_term;
`else
    assign en_eff = en;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [DW-1:0] raw;
        logic [DW-1:0] ld_val;

        assign raw            = data_in[gi*DW +: DW];
        assign bad_digit[gi]  = (int'(raw) >= RADIX);
        assign ld_val         = DW'(clamp_digit(int'(raw), RADIX));
        assign chain[gi+1]    = chain[gi] & at_term[gi];
        assign step[gi]       = en_eff & ~load & chain[gi];

        bcd_digit_cell #(
            .RADIX(RADIX)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .ld_val (ld_val),
            .step   (step[gi]),
            .up_down(up_down),
            .q_digit(q[gi*DW +: DW]),
            .at_term(at_term[gi])
        );
    end

    assign ovf_d      = en & ~load & all_term;
    assign load_err_d = load & (|bad_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = en & all_term;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: a 4x10 and a 2x16 instance checked against an integer model.
module tb_bcd_cascade_counter;

    localparam int RA = 10;
    localparam int DA = 4;
    localparam int RB = 16;
    localparam int DB = 2;
    localparam int DWX = 4;
`ifdef BCD_CASCADE_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst, en, load, up_down;
    logic [15:0] data_a, q_a;
    logic [7:0]  data_b, q_b;
    logic        tc_a, tc_b, ovf_a, ovf_b, lerr_a, lerr_b;

    int unsigned va, vb;
    bit          ovfa, ovfb, lerra, lerrb;
    logic [15:0] exp_qa;
    logic [7:0]  exp_qb;
    logic        tc_a_seen, tc_b_seen, tc_a_exp, tc_b_exp;
    int          n_cmp, n_bad;

    bcd_cascade_counter #(.DIGITS(DA), .RADIX(RA)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down),
        .data_in(data_a), .q(q_a), .tc(tc_a), .ovf(ovf_a), .load_err(lerr_a)
    );

    bcd_cascade_counter #(.DIGITS(DB), .RADIX(RB)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .up_down(up_down),
        .data_in(data_b), .q(q_b), .tc(tc_b), .ovf(ovf_b), .load_err(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ipow(input int r, input int d);
        int unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * r;
        return p;
    endfunction

    function automatic logic [31:0] to_packed(input int unsigned v, input int r, input int d, input int dw);
        logic [31:0] p = '0;
        int unsigned x = v;
        for (int i = 0; i < d; i++) begin
            p = p | (32'(x % r) << (i * dw));
            x = x / r;
        end
        return p;
    endfunction

    // Counter as a plain integer in [0, r**d - 1]; digits only matter at load time.
    task automatic model_step(input int unsigned v, input int r, input int d, input int dw,
                              input bit rs, input bit e, input bit ld, input bit ud,
                              input logic [31:0] data,
                              output int unsigned nv, output bit novf, output bit nlerr);
        int unsigned maxv = ipow(r, d) - 1;
        int unsigned dig;
        nv = v; novf = 1'b0; nlerr = 1'b0;
        if (rs) begin
            nv = 0;
        end else if (ld) begin
            nv = 0;
            for (int i = 0; i < d; i++) begin
                dig = (data >> (i * dw)) & ((32'd1 << dw) - 1);
                if (dig < r) nv = nv + dig * ipow(r, i);
                else nlerr = 1'b1;
            end
        end else if (e) begin
            if (ud) begin
                if (v == maxv) begin novf = 1'b1; nv = SAT ? maxv : 0; end
                else nv = v + 1;
            end else begin
                if (v == 0) begin novf = 1'b1; nv = SAT ? 0 : maxv; end
                else nv = v - 1;
            end
        end
    endtask

    // Drives one cycle on both DUTs, captures tc before the edge, advances the model.
    task automatic cycle(input bit r_i, input bit e_i, input bit l_i, input bit u_i,
                         input logic [15:0] da, input logic [7:0] db);
        int unsigned nva, nvb;
        rst = r_i; en = e_i; load = l_i; up_down = u_i; data_a = da; data_b = db;
        #1;
        tc_a_seen = tc_a;
        tc_b_seen = tc_b;
        tc_a_exp  = e_i && (u_i ? (va == ipow(RA, DA) - 1) : (va == 0));
        tc_b_exp  = e_i && (u_i ? (vb == ipow(RB, DB) - 1) : (vb == 0));
        @(posedge clk);
        model_step(va, RA, DA, DWX, r_i, e_i, l_i, u_i, 32'(da), nva, ovfa, lerra);
        model_step(vb, RB, DB, DWX, r_i, e_i, l_i, u_i, 32'(db), nvb, ovfb, lerrb);
        va = nva;
        vb = nvb;
        exp_qa = 16'(to_packed(va, RA, DA, DWX));
        exp_qb = 8'(to_packed(vb, RB, DB, DWX));
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 8'hAB);
        n_cmp++; if (q_a !== 16'h0000) begin n_bad++; $display("FAIL reset_q_a: got %h want 0000", q_a); end
        n_cmp++; if (q_b !== 8'h00) begin n_bad++; $display("FAIL reset_q_b: got %h want 00", q_b); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_a: got %b want 0", ovf_a); end
        n_cmp++; if (lerr_a !== 1'b0) begin n_bad++; $display("FAIL reset_lerr_a: got %b want 0", lerr_a); end
        $display("reset: q_a=%h q_b=%h", q_a, q_b);
    endtask

    task automatic test_count_up();
        logic [15:0] want;
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
            want = 16'(k);
            n_cmp++; if (q_a !== want) begin n_bad++; $display("FAIL count_up_q_a: got %h want %h", q_a, want); end
            n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL count_up_ovf_a: got %b want 0", ovf_a); end
            $display("count_up: q_a=%h q_b=%h", q_a, q_b);
        end
    endtask

    task automatic test_carry();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0998, 8'hFE);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
            n_cmp++; if (q_a !== exp_qa) begin n_bad++; $display("FAIL carry_q_a: got %h want %h", q_a, exp_qa); end
            n_cmp++; if (q_b !== exp_qb) begin n_bad++; $display("FAIL carry_q_b: got %h want %h", q_b, exp_qb); end
            n_cmp++; if (ovf_b !== ovfb) begin n_bad++; $display("FAIL carry_ovf_b: got %b want %b", ovf_b, ovfb); end
            $display("carry: q_a=%h q_b=%h ovf_b=%b", q_a, q_b, ovf_b);
        end
        n_cmp++; if (q_a !== 16'h1000) begin n_bad++; $display("FAIL carry_1000: got %h want 1000", q_a); end
    endtask

    task automatic test_full_scale(input bit ud, input logic [15:0] la, input logic [7:0] lb);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, la, lb);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, ud, '0, '0);
            n_cmp++; if (tc_a_seen !== tc_a_exp) begin n_bad++; $display("FAIL fs_tc_a: got %b want %b", tc_a_seen, tc_a_exp); end
            n_cmp++; if (tc_b_seen !== tc_b_exp) begin n_bad++; $display("FAIL fs_tc_b: got %b want %b", tc_b_seen, tc_b_exp); end
            n_cmp++; if (q_a !== exp_qa) begin n_bad++; $display("FAIL fs_q_a: got %h want %h", q_a, exp_qa); end
            n_cmp++; if (ovf_a !== ovfa) begin n_bad++; $display("FAIL fs_ovf_a: got %b want %b", ovf_a, ovfa); end
            n_cmp++; if (ovf_b !== ovfb) begin n_bad++; $display("FAIL fs_ovf_b: got %b want %b", ovf_b, ovfb); end
            $display("full_scale ud=%b: tc_a=%b q_a=%h ovf_a=%b", ud, tc_a_seen, q_a, ovf_a);
        end
        cycle(1'b0, 1'b0, 1'b0, ud, '0, '0);
        n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL fs_hold_ovf_a: got %b want 0", ovf_a); end
    endtask

    task automatic test_load_clamp();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h3C5F, 8'h7A);
        n_cmp++; if (q_a !== 16'h3050) begin n_bad++; $display("FAIL clamp_q_a: got %h want 3050", q_a); end
        n_cmp++; if (lerr_a !== 1'b1) begin n_bad++; $display("FAIL clamp_lerr_a: got %b want 1", lerr_a); end
        n_cmp++; if (lerr_b !== 1'b0) begin n_bad++; $display("FAIL clamp_lerr_b: got %b want 0", lerr_b); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL clamp_ovf_a: got %b want 0", ovf_a); end
        $display("load_clamp: q_a=%h lerr_a=%b", q_a, lerr_a);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        n_cmp++; if (q_a !== 16'h3051) begin n_bad++; $display("FAIL clamp_step_q_a: got %h want 3051", q_a); end
        n_cmp++; if (lerr_a !== 1'b0) begin n_bad++; $display("FAIL clamp_step_lerr_a: got %b want 0", lerr_a); end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
        n_cmp++; if (q_a !== 16'h0000) begin n_bad++; $display("FAIL midcount_rst_q_a: got %h want 0000", q_a); end
        $display("midcount_rst: q_a=%h q_b=%h", q_a, q_b);
    endtask

    task automatic test_random();
        bit          r_i, e_i, l_i, u_i;
        logic [15:0] da;
        logic [7:0]  db;
        for (int k = 0; k < 400; k++) begin
            r_i = ($urandom_range(0, 39) == 0);
            l_i = ($urandom_range(0, 7) == 0);
            e_i = ($urandom_range(0, 3) != 0);
            u_i = ($urandom_range(0, 1) == 1);
            da  = 16'($urandom);
            db  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) da = {4'h9, 4'h9, 4'h9, 4'($urandom_range(8, 9))};
            if ($urandom_range(0, 3) == 0) da = {12'h000, 4'($urandom_range(0, 1))};
            cycle(r_i, e_i, l_i, u_i, da, db);
            n_cmp++; if (tc_a_seen !== tc_a_exp) begin n_bad++; $display("FAIL rnd_tc_a: got %b want %b", tc_a_seen, tc_a_exp); end
            n_cmp++; if (tc_b_seen !== tc_b_exp) begin n_bad++; $display("FAIL rnd_tc_b: got %b want %b", tc_b_seen, tc_b_exp); end
            n_cmp++; if (q_a !== exp_qa) begin n_bad++; $display("FAIL rnd_q_a: got %h want %h", q_a, exp_qa); end
            n_cmp++; if (q_b !== exp_qb) begin n_bad++; $display("FAIL rnd_q_b: got %h want %h", q_b, exp_qb); end
            n_cmp++; if (ovf_a !== ovfa) begin n_bad++; $display("FAIL rnd_ovf_a: got %b want %b", ovf_a, ovfa); end
            n_cmp++; if (ovf_b !== ovfb) begin n_bad++; $display("FAIL rnd_ovf_b: got %b want %b", ovf_b, ovfb); end
            n_cmp++; if (lerr_a !== lerra) begin n_bad++; $display("FAIL rnd_lerr_a: got %b want %b", lerr_a, lerra); end
            n_cmp++; if (lerr_b !== lerrb) begin n_bad++; $display("FAIL rnd_lerr_b: got %b want %b", lerr_b, lerrb); end
            $display("rnd %0d: rst=%b ld=%b en=%b ud=%b q_a=%h q_b=%h ovf=%b%b lerr=%b", k, r_i, l_i, e_i, u_i, q_a, q_b, ovf_a, ovf_b, lerr_a);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        va = 0; vb = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; up_down = 1'b1; data_a = '0; data_b = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_count_up();
        test_carry();
        test_full_scale(1'b1, 16'h9999, 8'hFF);
        test_full_scale(1'b0, 16'h0000, 8'h00);
        test_load_clamp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
